// File: rtl/mips_pkg.sv
// Shared definitions for the mips_mmio_core codebase slice.
// Purpose: opcode and funct encodings of the supported MIPS subset, the ALU
// control enum and the default MMIO addresses of the GPIO ports.
// Ports: none (package).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [31:0] SW_ADDR_DEF  = 32'h0000_7FF0;
  localparam logic [31:0] LED_ADDR_DEF = 32'h0000_7FF4;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file with two combinational read ports and one write port.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset (clears all regs)
//   we, waddr, wdata  - write port, committed on the rising edge
//   raddr1/2, rdata1/2 - combinational read ports; register 0 always reads 0
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Writes to $0 are dropped so the register stays zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];

endmodule

// File: rtl/mips_mmio_core.sv
// Single-cycle MIPS-subset core with memory-mapped GPIO.
// Purpose: runs a ROM-resident polling program that copies the switch port to
// the LED register forever. Supports add/sub/and/or/slt, addi, lw, sw, beq, j;
// every other encoding executes as a NOP.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   switches    - GPIO inputs, read by lw from SW_ADDR
//   leds        - GPIO LED register, written by sw to LED_ADDR
//   pc_out      - current program counter
//   alu_result  - combinational ALU output (effective address for lw/sw)
module mips_mmio_core
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] SW_ADDR    = SW_ADDR_DEF,
  parameter logic [31:0] LED_ADDR   = LED_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm, pc_plus4;

  logic        reg_write, reg_dst_rd, alu_src_imm, mem_read, mem_write;
  logic        branch, jump;
  alu_ctrl_e   alu_ctrl;

  logic [31:0] rs_data, rt_data, alu_b, load_data, wb_data;
  logic [DMEM_AW-1:0] dmem_idx;
  logic        hit_sw, hit_led;
  logic        unused_bits;

  // Polling program: lw $t0,0x7FF0($0); sw $t0,0x7FF4($0); j 0.
  // Anything past the program (or past the ROM depth) reads as a NOP.
  always_comb begin
    instr = 32'h0000_0000;
    if (int'(pc_q[IMEM_AW+1:2]) < IMEM_WORDS) begin
      case (pc_q[IMEM_AW+1:2])
        IMEM_AW'(0): instr = 32'h8C08_7FF0;
        IMEM_AW'(1): instr = 32'hAC08_7FF4;
        IMEM_AW'(2): instr = 32'h0800_0000;
        default:     instr = 32'h0000_0000;
      endcase
    end
  end

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign target   = instr[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc_q + 32'd4;

  // Control decode. Unknown opcodes and unknown R-type functs leave every
  // enable low, which makes them NOPs.
  always_comb begin
    reg_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_ctrl    = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        case (funct)
          FN_ADD: begin reg_write = 1'b1; alu_ctrl = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; alu_ctrl = ALU_SUB; end
          FN_AND: begin reg_write = 1'b1; alu_ctrl = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; alu_ctrl = ALU_OR;  end
          FN_SLT: begin reg_write = 1'b1; alu_ctrl = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin reg_write = 1'b1; alu_src_imm = 1'b1; end
      OP_LW:   begin reg_write = 1'b1; alu_src_imm = 1'b1; mem_read = 1'b1; end
      OP_SW:   begin alu_src_imm = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin branch = 1'b1; alu_ctrl = ALU_SUB; end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  mips_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (reg_write),
    .waddr  (reg_dst_rd ? rd : rt),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_data),
    .rdata2 (rt_data)
  );

  assign alu_b = alu_src_imm ? sext_imm : rt_data;

  always_comb begin
    case (alu_ctrl)
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default: alu_result = rs_data + alu_b;
    endcase
  end

  // MMIO decode: the switch port shadows RAM for loads and swallows stores,
  // the LED register takes stores; every store hits exactly one target.
  assign hit_sw    = (alu_result == SW_ADDR);
  assign hit_led   = (alu_result == LED_ADDR);
  assign dmem_idx  = alu_result[DMEM_AW+1:2];
  assign load_data = hit_sw ? {24'd0, switches} : dmem_q[dmem_idx];
  assign wb_data   = mem_read ? load_data : alu_result;

  always_comb begin
    leds_d = leds_q;
    if (mem_write && hit_led) begin
      leds_d = rt_data[7:0];
    end
  end

  // beq compares via the SUB result being zero.
  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if (branch && (alu_result == 32'd0)) begin
      pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= 32'd0;
      leds_q <= 8'h00;
    end else begin
      pc_q   <= pc_d;
      leds_q <= leds_d;
    end
  end

  // Data RAM content is don't-care after reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_write && !hit_sw && !hit_led) begin
      dmem_q[dmem_idx] <= rt_data;
    end
  end

  assign unused_bits = ^{instr[10:6], alu_result, sext_imm[31:30]};

  assign leds   = leds_q;
  assign pc_out = pc_q;

endmodule

// File: tb/tb_mips_mmio_core.sv
// Directed testbench for mips_mmio_core: reset values, PC sequence of the
// polling program, switch-to-LED tracking, ALU address taps and mid-run reset.
module tb_mips_mmio_core;

  logic        clk;
  logic        rst_n;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic [31:0] pc_out;
  logic [31:0] alu_result;

  int checks;
  int failures;

  mips_mmio_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .switches   (switches),
    .leds       (leds),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held low through the first edge at 5 ns, released at 10 ns.
  task automatic test_reset();
    rst_n    = 1'b0;
    switches = 8'h00;
    #8;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'd0);
    end
    checks++;
    if (leds !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_leds: got %h expected %h", leds, 8'h00);
    end
    #2;
    rst_n = 1'b1;
  endtask

  // PC walks 0,4,8,0 on successive edges after release.
  task automatic test_pc_sequence();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'd0;
    exp_pc[1] = 32'd4;
    exp_pc[2] = 32'd8;
    exp_pc[3] = 32'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (pc_out !== exp_pc[i]) begin
        failures++;
        $display("[TB] FAIL pc_seq[%0d]: got %h expected %h", i, pc_out, exp_pc[i]);
      end
    end
  endtask

  // Switches at zero: LEDs must never leave zero.
  task automatic test_leds_idle();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (leds !== 8'h00) begin
        failures++;
        $display("[TB] FAIL leds_idle[%0d]: got %h expected %h", i, leds, 8'h00);
      end
    end
  endtask

  // New switch value must show on the LEDs within 4 edges and then hold.
  task automatic test_switch_track(input logic [7:0] val);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    switches = val;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (leds === val) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL track_%h: got %h expected %h within 4 edges", val, leds, val);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (leds !== val) begin
        failures++;
        $display("[TB] FAIL hold_%h[%0d]: got %h expected %h", val, i, leds, val);
      end
    end
  endtask

  // lw and sw present their effective addresses on alu_result.
  task automatic test_alu_taps();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(posedge clk);
      #1;
      if (pc_out === 32'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL alu_pc0_reach: got pc %h expected %h", pc_out, 32'd0);
    end else begin
      checks++;
      if (alu_result !== 32'h0000_7FF0) begin
        failures++;
        $display("[TB] FAIL alu_lw_addr: got %h expected %h", alu_result, 32'h0000_7FF0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc_out !== 32'd4) begin
        failures++;
        $display("[TB] FAIL alu_pc4: got %h expected %h", pc_out, 32'd4);
      end
      checks++;
      if (alu_result !== 32'h0000_7FF4) begin
        failures++;
        $display("[TB] FAIL alu_sw_addr: got %h expected %h", alu_result, 32'h0000_7FF4);
      end
    end
  endtask

  // Reset mid-run clears PC and LEDs asynchronously, then tracking resumes.
  task automatic test_midrun_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (leds !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_rst_leds: got %h expected %h", leds, 8'h00);
    end
    checks++;
    if (pc_out !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_rst_pc: got %h expected %h", pc_out, 32'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_hold_pc: got %h expected %h", pc_out, 32'd0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'd4) begin
      failures++;
      $display("[TB] FAIL rst_release_pc: got %h expected %h", pc_out, 32'd4);
    end
    test_switch_track(8'h3C);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_pc_sequence();
    test_leds_idle();
    test_switch_track(8'hAA);
    test_switch_track(8'h55);
    test_alu_taps();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
